// File: rtl/upd7800_pkg.sv
// Shared types and default constants for the uPD7800 bus target.
package upd7800_pkg;

    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned DEF_TIMEOUT = 16;
    localparam logic [ADDR_W-1:0] DEF_WP_TOP = 16'h0FFF;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_HOLD,
        WR_CAPT,
        WR_REQ
    } state_e;

    // Address/data pair presented to the backend.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_req_t;

endpackage

// File: rtl/upd7800_strobe_edge.sv
// Per-strobe history register with falling/rising edge flags.
// Edges are suppressed for the first cycle after reset so a strobe already low at release is ignored.
module upd7800_strobe_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic strobe_i,
    output logic fall_c,
    output logic rise_c
);

    logic hist_q;
    logic armed_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q  <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            hist_q  <= strobe_i;
            armed_q <= 1'b1;
        end
    end

    assign fall_c = armed_q & hist_q & ~strobe_i;
    assign rise_c = armed_q & ~hist_q & strobe_i;

endmodule

// File: rtl/upd7800_bus_target.sv
// uPD7800 CPU bus to request/acknowledge backend bridge with timeout and abort handling.
// Optional low-address write protection enabled by defining UPD7800_BUS_TARGET_WP_EN.
module upd7800_bus_target
    import upd7800_pkg::*;
#(
    parameter int unsigned       TIMEOUT = DEF_TIMEOUT,
    parameter logic [ADDR_W-1:0] WP_TOP  = DEF_WP_TOP
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] DB_I,
    output logic [DATA_W-1:0] DB_O,
    output logic              DB_OE,
    input  logic              M1,
    input  logic              RDB,
    input  logic              WRB,
    output logic [ADDR_W-1:0] MEM_A,
    output logic [DATA_W-1:0] MEM_D,
    output logic              MEM_RE,
    output logic              MEM_WE,
    input  logic [DATA_W-1:0] MEM_Q,
    input  logic              MEM_ACK,
    output logic              FETCH,
    output logic              ERR
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

`ifdef UPD7800_BUS_TARGET_WP_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif

    logic rd_fall_c, rd_rise_c, wr_fall_c, wr_rise_c;

    upd7800_strobe_edge u_rd_edge (
        .clk_i    (CLK),
        .rst_i    (RESET),
        .strobe_i (RDB),
        .fall_c   (rd_fall_c),
        .rise_c   (rd_rise_c)
    );

    upd7800_strobe_edge u_wr_edge (
        .clk_i    (CLK),
        .rst_i    (RESET),
        .strobe_i (WRB),
        .fall_c   (wr_fall_c),
        .rise_c   (wr_rise_c)
    );

    state_e            state_q, state_d;
    mem_req_t          req_q, req_d;
    logic [DATA_W-1:0] db_o_q, db_o_d;
    logic              db_oe_q, db_oe_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic              fetch_q, fetch_d;
    logic              err_q, err_d;
    logic              m1_flag_q, m1_flag_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [CNT_W-1:0]  cnt_inc_c;
    logic              timeout_c;
    logic              wp_hit_c;

    // Saturating wait counter; timeout fires in the cycle the count reaches TIMEOUT.
    assign cnt_inc_c = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);
    assign timeout_c = (cnt_inc_c == CNT_W'(TIMEOUT));
    assign wp_hit_c  = WP_EN && (req_q.addr <= WP_TOP);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            req_q     <= '0;
            db_o_q    <= '0;
            db_oe_q   <= 1'b0;
            mem_re_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            fetch_q   <= 1'b0;
            err_q     <= 1'b0;
            m1_flag_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            db_o_q    <= db_o_d;
            db_oe_q   <= db_oe_d;
            mem_re_q  <= mem_re_d;
            mem_we_q  <= mem_we_d;
            fetch_q   <= fetch_d;
            err_q     <= err_d;
            m1_flag_q <= m1_flag_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        db_o_d    = db_o_q;
        db_oe_d   = db_oe_q;
        mem_re_d  = mem_re_q;
        mem_we_d  = mem_we_q;
        m1_flag_d = m1_flag_q;
        cnt_d     = cnt_q;
        fetch_d   = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rd_fall_c) begin
                    // A simultaneous write strobe loses to the read and is flagged.
                    req_d.addr = A;
                    m1_flag_d  = M1;
                    mem_re_d   = 1'b1;
                    cnt_d      = '0;
                    err_d      = wr_fall_c;
                    state_d    = RD_REQ;
                end else if (wr_fall_c) begin
                    req_d.addr = A;
                    req_d.data = DB_I;
                    state_d    = WR_CAPT;
                end
            end
            RD_REQ: begin
                err_d = wr_fall_c;
                cnt_d = cnt_inc_c;
                // Abort wins over a coincident ACK so DB_OE never rises with RDB already high.
                if (rd_rise_c || (!MEM_ACK && timeout_c)) begin
                    mem_re_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end else if (MEM_ACK) begin
                    db_o_d   = MEM_Q;
                    db_oe_d  = 1'b1;
                    mem_re_d = 1'b0;
                    fetch_d  = m1_flag_q;
                    state_d  = RD_HOLD;
                end
            end
            RD_HOLD: begin
                err_d = wr_fall_c;
                if (rd_rise_c) begin
                    db_oe_d = 1'b0;
                    state_d = IDLE;
                end
            end
            WR_CAPT: begin
                err_d = rd_fall_c;
                if (!WRB) begin
                    req_d.addr = A;
                    req_d.data = DB_I;
                end else if (wr_rise_c) begin
                    if (wp_hit_c) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        mem_we_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = WR_REQ;
                    end
                end
            end
            WR_REQ: begin
                err_d = rd_fall_c;
                cnt_d = cnt_inc_c;
                if (MEM_ACK) begin
                    mem_we_d = 1'b0;
                    state_d  = IDLE;
                end else if (timeout_c) begin
                    mem_we_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign DB_O   = db_o_q;
    assign DB_OE  = db_oe_q;
    assign MEM_A  = req_q.addr;
    assign MEM_D  = req_q.data;
    assign MEM_RE = mem_re_q;
    assign MEM_WE = mem_we_q;
    assign FETCH  = fetch_q;
    assign ERR    = err_q;

endmodule

// File: tb/tb_upd7800_bus_target.sv
// Testbench for upd7800_bus_target: directed table, timing sequences and randomized transactions.
module tb_upd7800_bus_target;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] A = 16'h0000;
    logic [7:0]  DB_I = 8'h00;
    logic [7:0]  DB_O;
    logic        DB_OE;
    logic        M1 = 1'b0;
    logic        RDB = 1'b1;
    logic        WRB = 1'b1;
    logic [15:0] MEM_A;
    logic [7:0]  MEM_D;
    logic        MEM_RE;
    logic        MEM_WE;
    logic [7:0]  MEM_Q = 8'h00;
    logic        MEM_ACK = 1'b0;
    logic        FETCH;
    logic        ERR;

`ifdef UPD7800_BUS_TARGET_WP_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    upd7800_bus_target #(.TIMEOUT(16), .WP_TOP(16'h0FFF)) dut (
        .CLK(CLK), .RESET(RESET), .A(A), .DB_I(DB_I), .DB_O(DB_O), .DB_OE(DB_OE),
        .M1(M1), .RDB(RDB), .WRB(WRB), .MEM_A(MEM_A), .MEM_D(MEM_D),
        .MEM_RE(MEM_RE), .MEM_WE(MEM_WE), .MEM_Q(MEM_Q), .MEM_ACK(MEM_ACK),
        .FETCH(FETCH), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int fetch_cnt = 0, err_cnt = 0, overlap_cnt = 0, oe_run = 0, oe_viol = 0;
    bit auto_be = 1'b0;
    int be_lat = 0, be_wait = 0;

    logic [7:0] be_mem  [logic [15:0]];
    logic [7:0] ref_mem [logic [15:0]];

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  data;
        bit          m1;
        int          lat;
        logic [7:0]  exp_q;
        bit          exp_oe;
        int          exp_fetch;
        int          exp_err;
    } vec_t;

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return a[7:0] ^ 8'h5C;
    endfunction

    function automatic logic [7:0] be_rd(input logic [15:0] a);
        return be_mem.exists(a) ? be_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic bit is_prot(input logic [15:0] a);
        return WP && (a <= 16'h0FFF);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: sample outputs just after the edge, update monitors, run the backend responder.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (FETCH) fetch_cnt++;
        if (ERR) err_cnt++;
        if (MEM_RE && MEM_WE) overlap_cnt++;
        if (DB_OE && RDB) oe_run++; else oe_run = 0;
        if (oe_run > 1) oe_viol++;
        if (auto_be) begin
            MEM_ACK = 1'b0;
            if (MEM_RE || MEM_WE) begin
                be_wait++;
                if (be_lat != 0 && be_wait == be_lat) begin
                    MEM_ACK = 1'b1;
                    if (MEM_RE) MEM_Q = be_rd(MEM_A);
                    else        be_mem[MEM_A] = MEM_D;
                end
            end else begin
                be_wait = 0;
            end
        end
    endtask

    task automatic do_read(input logic [15:0] addr, input bit m1, input int lat,
                           output logic oe, output logic [7:0] q, output int df, output int de);
        int f0;
        int e0;
        f0 = fetch_cnt;
        e0 = err_cnt;
        be_lat = lat;
        be_wait = 0;
        oe = 1'b0;
        q = 8'h00;
        A = addr;
        M1 = m1;
        RDB = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (DB_OE) begin
                oe = 1'b1;
                q = DB_O;
                break;
            end
            if (!MEM_RE && i > 0) break;
        end
        tick();
        RDB = 1'b1;
        M1 = 1'b0;
        tick();
        tick();
        df = fetch_cnt - f0;
        de = err_cnt - e0;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] data, input int lat,
                            output logic we, output logic [15:0] wa, output logic [7:0] wd,
                            output int de);
        int e0;
        e0 = err_cnt;
        be_lat = lat;
        be_wait = 0;
        we = 1'b0;
        wa = 16'h0000;
        wd = 8'h00;
        A = 16'($urandom);
        DB_I = 8'($urandom);
        WRB = 1'b0;
        tick();
        A = addr;
        DB_I = data;
        tick();
        WRB = 1'b1;
        A = 16'($urandom);
        DB_I = 8'($urandom);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (MEM_WE) begin
                if (!we) begin
                    wa = MEM_A;
                    wd = MEM_D;
                end
                we = 1'b1;
            end else if (we || i >= 2) begin
                break;
            end
        end
        tick();
        de = err_cnt - e0;
        if (!is_prot(addr)) ref_mem[addr] = data;
    endtask

    // Exact-cycle read with a manually driven ACK on the second MEM_RE cycle.
    task automatic read_seq(input bit m1, input bit wr_glitch);
        int e0;
        int f0;
        e0 = err_cnt;
        f0 = fetch_cnt;
        A = 16'h1234; M1 = m1; RDB = 1'b0;
        tick();
        chk("rd_re_first", MEM_RE, 1);
        chk("rd_addr", MEM_A, 16'h1234);
        A = 16'hDEAD; M1 = 1'b0;
        tick();
        chk("rd_re_second", MEM_RE, 1);
        chk("rd_oe_before_ack", DB_OE, 0);
        MEM_Q = 8'hA5; MEM_ACK = 1'b1;
        tick();
        MEM_ACK = 1'b0; MEM_Q = 8'h00;
        chk("rd_re_dropped", MEM_RE, 0);
        chk("rd_oe_set", DB_OE, 1);
        chk("rd_data", DB_O, 8'hA5);
        chk("rd_fetch_pulse", FETCH, 32'(m1));
        if (wr_glitch) WRB = 1'b0;
        tick();
        WRB = 1'b1;
        chk("rd_fetch_single", FETCH, 0);
        tick();
        tick();
        chk("rd_oe_hold", DB_OE, 1);
        RDB = 1'b1;
        tick();
        chk("rd_oe_release", DB_OE, 0);
        tick();
        chk("rd_fetch_count", fetch_cnt - f0, 32'(m1));
        chk("rd_err_count", err_cnt - e0, 32'(wr_glitch));
    endtask

    vec_t        tbl [12];
    logic [15:0] pool [8];
    logic        oe, we;
    logic [7:0]  q, wd, exp_q, data;
    logic [15:0] wa, addr;
    int          df, de, e0, lat, re_cycles;
    bit          flag, m1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 16'h8000, 8'h22, 1'b0, 2,  8'h00, 1'b0, 0, 0};
        tbl[1]  = '{1'b0, 16'h8000, 8'h00, 1'b0, 1,  8'h22, 1'b1, 0, 0};
        tbl[2]  = '{1'b0, 16'h8000, 8'h00, 1'b1, 3,  8'h22, 1'b1, 1, 0};
        tbl[3]  = '{1'b0, 16'h4321, 8'h00, 1'b0, 2,  8'h7D, 1'b1, 0, 0};
        tbl[4]  = '{1'b0, 16'h1111, 8'h00, 1'b1, 0,  8'h00, 1'b0, 0, 1};
        tbl[5]  = '{1'b1, 16'h0800, 8'h5A, 1'b0, 1,  8'h00, 1'b0, 0, int'(WP)};
        tbl[6]  = '{1'b0, 16'h0800, 8'h00, 1'b1, 1,  WP ? 8'h5C : 8'h5A, 1'b1, 1, 0};
        tbl[7]  = '{1'b1, 16'h1000, 8'hC3, 1'b0, 4,  8'h00, 1'b0, 0, 0};
        tbl[8]  = '{1'b0, 16'h1000, 8'h00, 1'b0, 16, 8'hC3, 1'b1, 0, 0};
        tbl[9]  = '{1'b0, 16'h0FFF, 8'h00, 1'b0, 2,  8'hA3, 1'b1, 0, 0};
        tbl[10] = '{1'b1, 16'h0FFF, 8'h99, 1'b0, 2,  8'h00, 1'b0, 0, int'(WP)};
        tbl[11] = '{1'b0, 16'h0FFF, 8'h00, 1'b0, 2,  WP ? 8'hA3 : 8'h99, 1'b1, 0, 0};
        pool = '{16'h0000, 16'h0800, 16'h0FFF, 16'h1000, 16'h1234, 16'h8000, 16'hFFFE, 16'hABCD};

        // Reset state
        tick(); tick(); tick();
        chk("rst_db_oe", DB_OE, 0);
        chk("rst_mem_re", MEM_RE, 0);
        chk("rst_mem_we", MEM_WE, 0);
        chk("rst_fetch", FETCH, 0);
        chk("rst_err", ERR, 0);
        chk("rst_db_o", DB_O, 8'h00);
        chk("rst_mem_a", MEM_A, 16'h0000);
        chk("rst_mem_d", MEM_D, 8'h00);
        RESET = 1'b0;
        tick(); tick();

        // Directed transaction table
        auto_be = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (tbl[k].wr) begin
                do_write(tbl[k].addr, tbl[k].data, tbl[k].lat, we, wa, wd, de);
                chk($sformatf("tbl%0d_err", k), de, tbl[k].exp_err);
                chk($sformatf("tbl%0d_we", k), we, 32'(tbl[k].exp_err == 0));
                if (tbl[k].exp_err == 0) begin
                    chk($sformatf("tbl%0d_mem_a", k), wa, tbl[k].addr);
                    chk($sformatf("tbl%0d_mem_d", k), wd, tbl[k].data);
                end
            end else begin
                do_read(tbl[k].addr, tbl[k].m1, tbl[k].lat, oe, q, df, de);
                chk($sformatf("tbl%0d_oe", k), oe, tbl[k].exp_oe);
                if (tbl[k].exp_oe) chk($sformatf("tbl%0d_data", k), q, tbl[k].exp_q);
                chk($sformatf("tbl%0d_fetch", k), df, tbl[k].exp_fetch);
                chk($sformatf("tbl%0d_err", k), de, tbl[k].exp_err);
            end
        end
        auto_be = 1'b0;
        MEM_ACK = 1'b0;
        tick();

        // Plain read, then fetch read with a write strobe falling during the hold
        read_seq(1'b0, 1'b0);
        read_seq(1'b1, 1'b1);

        // Abort before ACK, followed by a late ACK
        e0 = err_cnt;
        A = 16'h3333; RDB = 1'b0;
        tick();
        chk("ab_re", MEM_RE, 1);
        RDB = 1'b1;
        tick();
        chk("ab_re_drop", MEM_RE, 0);
        chk("ab_err_pulse", ERR, 1);
        chk("ab_oe", DB_OE, 0);
        MEM_Q = 8'h77; MEM_ACK = 1'b1;
        tick();
        MEM_ACK = 1'b0;
        tick();
        chk("ab_late_oe", DB_OE, 0);
        chk("ab_late_db_o", DB_O, 8'hA5);
        chk("ab_late_re", MEM_RE, 0);
        chk("ab_err_count", err_cnt - e0, 1);

        // Write with data changing while WRB is low; last value wins
        e0 = err_cnt;
        A = 16'h8000; DB_I = 8'h11; WRB = 1'b0;
        tick();
        DB_I = 8'h22;
        tick();
        WRB = 1'b1; A = 16'hFFFF; DB_I = 8'h33;
        tick();
        chk("wr_we", MEM_WE, 1);
        chk("wr_re_off", MEM_RE, 0);
        chk("wr_mem_a", MEM_A, 16'h8000);
        chk("wr_mem_d", MEM_D, 8'h22);
        MEM_ACK = 1'b1;
        tick();
        MEM_ACK = 1'b0;
        chk("wr_we_drop", MEM_WE, 0);
        tick();
        chk("wr_err_count", err_cnt - e0, 0);

        // Read timeout with no ACK
        e0 = err_cnt;
        re_cycles = 0;
        flag = 1'b0;
        A = 16'h2000; RDB = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (DB_OE) flag = 1'b1;
            if (MEM_RE) re_cycles++;
            else if (i > 0) break;
        end
        chk("to_re_cycles", re_cycles, 16);
        chk("to_err_pulse", ERR, 1);
        RDB = 1'b1;
        tick(); tick();
        chk("to_oe_seen", flag, 0);
        chk("to_err_count", err_cnt - e0, 1);

        // Both strobes fall together: read serviced, write ignored, ERR
        e0 = err_cnt;
        flag = 1'b0;
        A = 16'h5555; RDB = 1'b0; WRB = 1'b0;
        tick();
        chk("both_re", MEM_RE, 1);
        chk("both_we", MEM_WE, 0);
        chk("both_err", ERR, 1);
        MEM_Q = 8'h3C; MEM_ACK = 1'b1;
        tick();
        MEM_ACK = 1'b0;
        chk("both_oe", DB_OE, 1);
        chk("both_data", DB_O, 8'h3C);
        RDB = 1'b1; WRB = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (MEM_WE) flag = 1'b1;
        end
        chk("both_oe_off", DB_OE, 0);
        chk("both_no_we", flag, 0);
        chk("both_err_count", err_cnt - e0, 1);

        // Reset while in RD_REQ; strobe still low at release
        e0 = err_cnt;
        flag = 1'b0;
        A = 16'h2468; RDB = 1'b0;
        tick();
        chk("mr_re", MEM_RE, 1);
        RESET = 1'b1;
        tick();
        chk("mr_re_off", MEM_RE, 0);
        chk("mr_mem_a", MEM_A, 16'h0000);
        chk("mr_db_o", DB_O, 8'h00);
        chk("mr_oe", DB_OE, 0);
        chk("mr_err", ERR, 0);
        MEM_ACK = 1'b1;
        tick();
        MEM_ACK = 1'b0;
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (MEM_RE || DB_OE) flag = 1'b1;
        end
        chk("mr_no_req_after", flag, 0);
        RDB = 1'b1;
        tick(); tick();
        chk("mr_err_count", err_cnt - e0, 0);

        // Randomized transactions against the reference memory model
        auto_be = 1'b1;
        for (int n = 0; n < 80; n++) begin
            addr = pool[$urandom_range(0, 7)];
            lat = int'($urandom_range(1, 6));
            if ($urandom_range(0, 1) == 1) begin
                data = 8'($urandom);
                flag = is_prot(addr);
                do_write(addr, data, lat, we, wa, wd, de);
                chk($sformatf("rnd%0d_wr_err", n), de, 32'(flag));
                chk($sformatf("rnd%0d_wr_we", n), we, 32'(!flag));
                if (!flag) begin
                    chk($sformatf("rnd%0d_wr_a", n), wa, addr);
                    chk($sformatf("rnd%0d_wr_d", n), wd, data);
                end
            end else begin
                m1 = 1'($urandom);
                exp_q = ref_rd(addr);
                do_read(addr, m1, lat, oe, q, df, de);
                chk($sformatf("rnd%0d_rd_oe", n), oe, 1);
                chk($sformatf("rnd%0d_rd_data", n), q, exp_q);
                chk($sformatf("rnd%0d_rd_fetch", n), df, 32'(m1));
                chk($sformatf("rnd%0d_rd_err", n), de, 0);
            end
        end
        auto_be = 1'b0;
        MEM_ACK = 1'b0;
        tick();

        chk("re_we_overlap", overlap_cnt, 0);
        chk("oe_while_rdb_high", oe_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
